// File: rtl/program_loader.sv
// Writable program store with a streaming load controller for the accumulator CPU.
// The controller clears the store, accepts a new program over valid/ready, and keeps the CPU in reset until the load completes.
module program_loader #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 6
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          IN_VALID,
   input  logic [DW-1:0] IN_DATA,
   input  logic          IN_LAST,
   output logic          IN_READY,
   input  logic [AW-1:0] ADDR,
   output logic [DW-1:0] DATA,
   output logic          CPU_nRST,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR,
   output logic [AW:0]   WCOUNT
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      LOAD  = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] cptr;
   logic [AW-1:0] wptr;
   logic          xfer;
   logic          clear_end;
   logic          last_slot;
   logic          start_clear;
   logic          done_set;
   logic          err_set;

   logic [DW-1:0] mem [DEPTH];

   assign xfer      = (state == LOAD) && IN_VALID;
   assign clear_end = (cptr == AW'(DEPTH - 1));
   assign last_slot = (WCOUNT == (AW + 1)'(DEPTH - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      start_clear = 1'b0;
      done_set    = 1'b0;
      err_set     = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               state_next  = CLEAR;
               start_clear = 1'b1;
            end
         end
         CLEAR: begin
            if (clear_end) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            // A final word that exactly fills the store still counts as a clean completion.
            if (xfer) begin
               if (IN_LAST) begin
                  state_next = RUN;
                  done_set   = 1'b1;
               end else if (last_slot) begin
                  state_next = IDLE;
                  err_set    = 1'b1;
               end
            end
         end
         RUN: begin
            if (START) begin
               state_next  = CLEAR;
               start_clear = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cptr   <= '0;
         wptr   <= '0;
         WCOUNT <= '0;
         ERR    <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         DONE <= done_set;
         if (start_clear) begin
            cptr   <= '0;
            wptr   <= '0;
            WCOUNT <= '0;
            ERR    <= 1'b0;
         end else begin
            if (state == CLEAR) begin
               cptr <= cptr + AW'(1);
            end
            if (xfer) begin
               wptr   <= wptr + AW'(1);
               WCOUNT <= WCOUNT + (AW + 1)'(1);
            end
            if (err_set) begin
               ERR <= 1'b1;
            end
         end
      end
   end

   // The store itself is never reset; the CPU stays in reset until a load has defined it.
   always_ff @(posedge CLK) begin
      if (state == CLEAR) begin
         mem[cptr] <= '0;
      end else if (xfer) begin
         mem[wptr] <= IN_DATA;
      end
   end

   assign DATA     = mem[ADDR];
   assign IN_READY = (state == LOAD);
   assign BUSY     = (state == CLEAR) || (state == LOAD);
   assign CPU_nRST = (state == RUN);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a phase/queue-level model checked every cycle, plus directed load scenarios.
module tb_program_loader;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int DW    = 6;
   localparam int M_IDLE  = 0;
   localparam int M_CLEAR = 1;
   localparam int M_LOAD  = 2;
   localparam int M_RUN   = 3;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START;
   logic          IN_VALID;
   logic [DW-1:0] IN_DATA;
   logic          IN_LAST;
   logic          IN_READY;
   logic [AW-1:0] ADDR;
   logic [DW-1:0] DATA;
   logic          CPU_nRST;
   logic          BUSY;
   logic          DONE;
   logic          ERR;
   logic [AW:0]   WCOUNT;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] words [DEPTH];

   int            m_mode = M_IDLE;
   int            m_clr  = 0;
   int            m_wc   = 0;
   bit            m_err  = 1'b0;
   bit            m_done = 1'b0;
   logic [DW-1:0] m_mem   [DEPTH];
   bit            m_known [DEPTH];

   always #5 CLK = ~CLK;

   program_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .IN_VALID (IN_VALID),
      .IN_DATA  (IN_DATA),
      .IN_LAST  (IN_LAST),
      .IN_READY (IN_READY),
      .ADDR     (ADDR),
      .DATA     (DATA),
      .CPU_nRST (CPU_nRST),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .ERR      (ERR),
      .WCOUNT   (WCOUNT)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a clear phase of DEPTH writes, then a word queue appended at the accepted count.
   always @(posedge CLK or posedge RST) begin
      int md, cl, wc;
      bit er, dn;
      if (RST) begin
         m_mode <= M_IDLE;
         m_clr  <= 0;
         m_wc   <= 0;
         m_err  <= 1'b0;
         m_done <= 1'b0;
      end else begin
         md = m_mode; cl = m_clr; wc = m_wc; er = m_err; dn = 1'b0;
         if (md == M_IDLE || md == M_RUN) begin
            if (START) begin
               md = M_CLEAR; cl = 0; wc = 0; er = 1'b0;
            end
         end else if (md == M_CLEAR) begin
            m_mem[cl]   <= '0;
            m_known[cl] <= 1'b1;
            cl = cl + 1;
            if (cl == DEPTH) md = M_LOAD;
         end else if (IN_VALID) begin
            m_mem[wc % DEPTH]   <= IN_DATA;
            m_known[wc % DEPTH] <= 1'b1;
            wc = wc + 1;
            if (IN_LAST) begin
               md = M_RUN; dn = 1'b1;
            end else if (wc == DEPTH) begin
               md = M_IDLE; er = 1'b1;
            end
         end
         m_mode <= md; m_clr <= cl; m_wc <= wc; m_err <= er; m_done <= dn;
      end
   end

   always @(negedge CLK) begin
      chk("cpu_nrst", int'(CPU_nRST), int'(m_mode == M_RUN));
      chk("busy", int'(BUSY), int'(m_mode == M_CLEAR || m_mode == M_LOAD));
      chk("in_ready", int'(IN_READY), int'(m_mode == M_LOAD));
      chk("done", int'(DONE), int'(m_done));
      chk("err", int'(ERR), int'(m_err));
      chk("wcount", int'(WCOUNT), m_wc);
      if (m_known[ADDR]) chk("data", int'(DATA), int'(m_mem[ADDR]));
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #2;
      ADDR = AW'($urandom_range(0, DEPTH - 1));
   endtask

   task automatic wait_load(output int n);
      n = 0;
      while (!IN_READY && n < 100) begin
         n++;
         tick();
      end
      if (!IN_READY) chk("load_entry_timeout", 0, 1);
   endtask

   task automatic send(input int n, input bit last, input bit gaps, output int cyc);
      int  i;
      bit  taken;
      i   = 0;
      cyc = 0;
      while (i < n && cyc < 1000) begin
         IN_DATA  = words[i];
         IN_LAST  = last && (i == n - 1);
         IN_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         START    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
         taken    = IN_VALID && IN_READY;
         tick();
         cyc++;
         if (taken) i++;
      end
      IN_VALID = 1'b0;
      IN_LAST  = 1'b0;
      START    = 1'b0;
      if (i < n) chk("send_timeout", i, n);
   endtask

   task automatic check_mem(input int n);
      for (int a = 0; a < DEPTH; a++) begin
         ADDR = AW'(a);
         #1;
         chk("readback", int'(DATA), (a < n) ? int'(words[a]) : 0);
      end
      tick();
   endtask

   task automatic kick();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   initial begin
      int n, cyc;
      RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; IN_DATA = '0; ADDR = '0;
      repeat (2) @(posedge CLK);
      #2;
      RST = 1'b0;
      chk("rst_nrst", int'(CPU_nRST), 0);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_ready", int'(IN_READY), 0);
      chk("rst_wcount", int'(WCOUNT), 0);

      // Nominal four-word program
      words[0] = 6'h11; words[1] = 6'h22; words[2] = 6'h33; words[3] = 6'h3F;
      kick();
      chk("clear_busy", int'(BUSY), 1);
      chk("clear_nrst", int'(CPU_nRST), 0);
      wait_load(n);
      chk("clear_len", n, 32);
      send(4, 1'b1, 1'b0, cyc);
      chk("xfer_cycles", cyc, 4);
      chk("nom_done", int'(DONE), 1);
      chk("nom_nrst", int'(CPU_nRST), 1);
      chk("nom_wcount", int'(WCOUNT), 4);
      chk("nom_ready", int'(IN_READY), 0);
      tick();
      chk("nom_done_pulse", int'(DONE), 0);
      check_mem(4);

      // Reload from RUN with random gaps and stray START during LOAD
      words[0] = 6'h05; words[1] = 6'h0A; words[2] = 6'h15;
      words[3] = 6'h2A; words[4] = 6'h01; words[5] = 6'h3E;
      kick();
      chk("reload_nrst", int'(CPU_nRST), 0);
      wait_load(n);
      send(6, 1'b1, 1'b1, cyc);
      chk("gap_wcount", int'(WCOUNT), 6);
      chk("gap_nrst", int'(CPU_nRST), 1);
      check_mem(6);

      // Short reload: old words at 2..5 must be cleared
      words[0] = 6'h07; words[1] = 6'h09;
      kick();
      wait_load(n);
      send(2, 1'b1, 1'b0, cyc);
      check_mem(2);

      // Mid-cycle reset from RUN, no clock edge
      RST = 1'b1;
      #1;
      chk("async_nrst", int'(CPU_nRST), 0);
      chk("async_wcount", int'(WCOUNT), 0);
      chk("async_busy", int'(BUSY), 0);
      tick();
      RST = 1'b0;

      // Overflow: 32 words, no IN_LAST
      for (int i = 0; i < DEPTH; i++) words[i] = DW'((i * 5 + 3) % 64);
      kick();
      wait_load(n);
      send(32, 1'b0, 1'b0, cyc);
      chk("ovf_err", int'(ERR), 1);
      chk("ovf_nrst", int'(CPU_nRST), 0);
      chk("ovf_busy", int'(BUSY), 0);
      chk("ovf_done", int'(DONE), 0);
      chk("ovf_wcount", int'(WCOUNT), 32);
      IN_VALID = 1'b1; IN_DATA = 6'h2A;
      repeat (3) tick();
      IN_VALID = 1'b0;
      chk("ovf_ready", int'(IN_READY), 0);
      chk("ovf_wcount_hold", int'(WCOUNT), 32);
      chk("ovf_err_hold", int'(ERR), 1);
      check_mem(32);

      // Exact fill: 32 words with IN_LAST on the last
      for (int i = 0; i < DEPTH; i++) words[i] = DW'(63 - i);
      kick();
      chk("restart_err", int'(ERR), 0);
      chk("restart_wcount", int'(WCOUNT), 0);
      wait_load(n);
      send(32, 1'b1, 1'b0, cyc);
      chk("fill_done", int'(DONE), 1);
      chk("fill_err", int'(ERR), 0);
      chk("fill_nrst", int'(CPU_nRST), 1);
      chk("fill_wcount", int'(WCOUNT), 32);
      check_mem(32);

      // Abort after the second word
      words[0] = 6'h31; words[1] = 6'h32;
      kick();
      wait_load(n);
      send(2, 1'b0, 1'b0, cyc);
      chk("abort_pre_wcount", int'(WCOUNT), 2);
      RST = 1'b1;
      #1;
      chk("abort_busy", int'(BUSY), 0);
      chk("abort_ready", int'(IN_READY), 0);
      chk("abort_nrst", int'(CPU_nRST), 0);
      chk("abort_wcount", int'(WCOUNT), 0);
      tick();
      RST = 1'b0;
      kick();
      chk("abort_restart_busy", int'(BUSY), 1);
      chk("abort_restart_wcount", int'(WCOUNT), 0);
      words[0] = 6'h1C;
      wait_load(n);
      chk("abort_clear_len", n, 32);
      send(1, 1'b1, 1'b0, cyc);
      check_mem(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
